// File: rtl/nearest_hit_resolver_pkg.sv
// Shared ray-tracing types: fixed-point format, hit record and resolver FSM states.
package rt_pkg;

  localparam int TOTAL_PREC = 27;
  localparam int FRAC_BITS  = 22;
  // Widest triangle index a hit record can carry.
  localparam int REC_IDX_W  = 16;

  typedef logic signed [TOTAL_PREC-1:0] fixed_t;
  typedef fixed_t [2:0] vec3_t;

  // 1.0 in the fixed-point format.
  localparam fixed_t FIX_ONE = 27'sd4194304;

  typedef struct packed {
    logic                 hit;
    logic [REC_IDX_W-1:0] idx;
    fixed_t               t;
    fixed_t               oa;
  } hit_rec_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

endpackage

// File: rtl/nearest_hit_resolver_tag_pipe.sv
// Shift register of {valid, idx} tags that tracks which triangle index each
// intersector result belongs to. any_valid reports entries that are still in
// flight behind the tail, i.e. the pipe will be empty once the current tail
// entry has been compared.
module hit_tag_pipe #(
  parameter int DEPTH = 6,
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_valid,
  input  logic [IDX_W-1:0] load_idx,
  output logic             tail_valid,
  output logic [IDX_W-1:0] tail_idx,
  output logic             any_valid
);

  // Every stage except the tail counts as pending.
  localparam logic [DEPTH-1:0] PEND_MASK = ~(DEPTH'(1) << (DEPTH - 1));

  logic [DEPTH-1:0] valid_vec;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic             valid_reg;
      logic [IDX_W-1:0] idx_reg;
      logic             valid_next;
      logic [IDX_W-1:0] idx_next;

      if (gi == 0) begin : g_head
        assign valid_next = load_valid;
        assign idx_next   = load_idx;
      end else begin : g_body
        assign valid_next = g_stage[gi-1].valid_reg;
        assign idx_next   = g_stage[gi-1].idx_reg;
      end

      // Advance this stage by one each cycle; reset flushes every tag.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          valid_reg <= 1'b0;
          idx_reg   <= '0;
        end else begin
          valid_reg <= valid_next;
          idx_reg   <= idx_next;
        end
      end

      assign valid_vec[gi] = valid_reg;
    end
  endgenerate

  assign tail_valid = g_stage[DEPTH-1].valid_reg;
  assign tail_idx   = g_stage[DEPTH-1].idx_reg;
  assign any_valid  = |(valid_vec & PEND_MASK);

endmodule

// File: rtl/nearest_hit_resolver.sv
// Sweeps all triangles for one ray through the intersector, keeps the nearest
// positive-determinant hit and hands the record to the shading stage.
module nearest_hit_resolver
  import rt_pkg::*;
#(
  parameter int TRI_COUNT = 64,
  parameter int IDX_W     = $clog2(TRI_COUNT),
  parameter int PIPE_LAT  = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ray_valid,
  output logic             ray_ready,
  input  vec3_t            ray_dir,
  output vec3_t            dir_out,
  output logic [IDX_W-1:0] tri_idx,
  output logic             tri_issue,
  input  fixed_t           isect_oa,
  input  fixed_t           isect_t,
  input  logic             isect_hit,
  output logic             res_valid,
  input  logic             res_ready,
  output logic             res_hit,
  output logic [IDX_W-1:0] res_idx,
  output fixed_t           res_t,
  output fixed_t           res_oa
);

  localparam int               PW       = 2 * TOTAL_PREC;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(TRI_COUNT - 1);

  state_t           state_reg;
  logic             ray_ready_reg;
  logic             tri_issue_reg;
  logic [IDX_W-1:0] tri_idx_reg;
  logic             res_valid_reg;
  vec3_t            dir_reg;
  hit_rec_t         best_reg;

  logic             tail_valid;
  logic [IDX_W-1:0] tail_idx;
  logic             any_valid;

  // Tag pipe mirrors the memory + intersector latency so each result can be
  // matched to the index that produced it.
  hit_tag_pipe #(
    .DEPTH (PIPE_LAT),
    .IDX_W (IDX_W)
  ) u_tag_pipe (
    .clk        (clk),
    .rst        (rst),
    .load_valid (tri_issue_reg),
    .load_idx   (tri_idx_reg),
    .tail_valid (tail_valid),
    .tail_idx   (tail_idx),
    .any_valid  (any_valid)
  );

  // Division-free distance compare: t_c/oa_c < t_b/oa_b  <=>  t_c*oa_b < t_b*oa_c,
  // valid because both determinants are strictly positive. Full-width products
  // keep the comparison exact.
  logic signed [PW-1:0] cand_t_x, cand_oa_x, best_t_x, best_oa_x;
  logic signed [PW-1:0] cand_prod, best_prod;
  logic                 oa_positive, qualify, nearer, sweep_active, best_upd;
  hit_rec_t             cand_rec;

  assign cand_t_x     = PW'(isect_t);
  assign cand_oa_x    = PW'(isect_oa);
  assign best_t_x     = PW'(best_reg.t);
  assign best_oa_x    = PW'(best_reg.oa);
  assign cand_prod    = cand_t_x * best_oa_x;
  assign best_prod    = best_t_x * cand_oa_x;
  assign nearer       = cand_prod < best_prod;
  assign oa_positive  = !isect_oa[TOTAL_PREC-1] && (isect_oa != '0);
  assign qualify      = tail_valid && isect_hit && oa_positive;
  assign sweep_active = (state_reg == ISSUE) || (state_reg == DRAIN);
  // Strict compare keeps the earlier-issued index on equal distances.
  assign best_upd     = sweep_active && qualify && (!best_reg.hit || nearer);

  assign cand_rec.hit = 1'b1;
  assign cand_rec.idx = REC_IDX_W'(tail_idx);
  assign cand_rec.t   = isect_t;
  assign cand_rec.oa  = isect_oa;

  // Resolver FSM with registered handshake/issue outputs and best-record update.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg     <= IDLE;
      ray_ready_reg <= 1'b1;
      tri_issue_reg <= 1'b0;
      tri_idx_reg   <= '0;
      res_valid_reg <= 1'b0;
      dir_reg       <= '0;
      best_reg      <= '0;
    end else begin
      if (best_upd) begin
        best_reg <= cand_rec;
      end
      case (state_reg)
        IDLE: begin
          if (ray_valid && ray_ready_reg) begin
            dir_reg       <= ray_dir;
            best_reg      <= '0;
            ray_ready_reg <= 1'b0;
            tri_issue_reg <= 1'b1;
            tri_idx_reg   <= '0;
            state_reg     <= ISSUE;
          end
        end
        ISSUE: begin
          if (tri_idx_reg == LAST_IDX) begin
            tri_issue_reg <= 1'b0;
            tri_idx_reg   <= '0;
            state_reg     <= DRAIN;
          end else begin
            tri_idx_reg <= tri_idx_reg + 1'b1;
          end
        end
        DRAIN: begin
          if (!any_valid) begin
            res_valid_reg <= 1'b1;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (res_ready) begin
            res_valid_reg <= 1'b0;
            ray_ready_reg <= 1'b1;
            state_reg     <= IDLE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign ray_ready = ray_ready_reg;
  assign tri_issue = tri_issue_reg;
  assign tri_idx   = tri_idx_reg;
  assign dir_out   = dir_reg;
  assign res_valid = res_valid_reg;
  assign res_hit   = best_reg.hit;
  assign res_idx   = best_reg.idx[IDX_W-1:0];
  assign res_t     = best_reg.t;
  assign res_oa    = best_reg.oa;

endmodule

// File: tb/tb_nearest_hit_resolver.sv
// Directed bench for nearest_hit_resolver with a 4-triangle scene and a
// 6-cycle intersector; isect_* is driven from a per-index table on the cycle
// each index reaches the tail, and with a tempting near hit on every other cycle.
module tb_nearest_hit_resolver;
  import rt_pkg::*;

  localparam int TC = 4;
  localparam int PL = 6;
  localparam int IW = 2;

  localparam fixed_t ONE   = 27'sd4194304;
  localparam fixed_t TWO   = 27'sd8388608;
  localparam fixed_t THREE = 27'sd12582912;
  localparam fixed_t EIGHTH = 27'sd524288;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          ray_valid = 1'b0;
  logic          ray_ready;
  vec3_t         ray_dir = '0;
  vec3_t         dir_out;
  logic [IW-1:0] tri_idx;
  logic          tri_issue;
  fixed_t        isect_oa = '0;
  fixed_t        isect_t = '0;
  logic          isect_hit = 1'b0;
  logic          res_valid;
  logic          res_ready = 1'b0;
  logic          res_hit;
  logic [IW-1:0] res_idx;
  fixed_t        res_t;
  fixed_t        res_oa;

  int vectors = 0;
  int miscompares = 0;

  fixed_t tab_t   [TC];
  fixed_t tab_oa  [TC];
  logic   tab_hit [TC];

  always #5 clk = ~clk;

  nearest_hit_resolver #(
    .TRI_COUNT (TC),
    .PIPE_LAT  (PL)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .ray_valid (ray_valid),
    .ray_ready (ray_ready),
    .ray_dir   (ray_dir),
    .dir_out   (dir_out),
    .tri_idx   (tri_idx),
    .tri_issue (tri_issue),
    .isect_oa  (isect_oa),
    .isect_t   (isect_t),
    .isect_hit (isect_hit),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_hit   (res_hit),
    .res_idx   (res_idx),
    .res_t     (res_t),
    .res_oa    (res_oa)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      $error("check %s miscompared", tag);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Non-hit entries carry a plausible t/oa so an ignored hit flag would show.
  task automatic clear_tab();
    for (int i = 0; i < TC; i++) begin
      tab_hit[i] = 1'b0;
      tab_t[i]   = ONE;
      tab_oa[i]  = ONE;
    end
  endtask

  // c = cycles since the accept edge; index i reaches the tail at c = PL+1+i.
  task automatic drive_isect(input int c);
    int i;
    i = c - 1 - PL;
    if (i >= 0 && i < TC) begin
      isect_hit = tab_hit[i];
      isect_t   = tab_t[i];
      isect_oa  = tab_oa[i];
    end else begin
      isect_hit = 1'b1;
      isect_t   = EIGHTH;
      isect_oa  = ONE;
    end
  endtask

  task automatic start_ray(input fixed_t d0);
    ray_dir[0] = d0;
    ray_dir[1] = ONE;
    ray_dir[2] = -ONE;
    ray_valid  = 1'b1;
    check("ray_ready_before_accept", 64'(ray_ready), 64'd1);
    tick();
    ray_valid = 1'b0;
    check("dir_out_latched", 64'(dir_out[0]), 64'(d0));
  endtask

  task automatic run_sweep();
    for (int c = 1; c <= TC + PL; c++) begin
      drive_isect(c);
      if (c == 1) begin
        check("issue_first_valid", 64'(tri_issue), 64'd1);
        check("issue_first_idx", 64'(tri_idx), 64'd0);
      end
      if (c == TC) check("issue_last_idx", 64'(tri_idx), 64'(TC - 1));
      if (c == TC + 1) check("drain_no_issue", 64'(tri_issue), 64'd0);
      if (c == TC + PL) check("res_valid_not_early", 64'(res_valid), 64'd0);
      tick();
    end
    drive_isect(TC + PL + 1);
    check("res_valid_at_k11", 64'(res_valid), 64'd1);
  endtask

  task automatic check_result(input logic hit, input int idx, input fixed_t t, input fixed_t oa);
    check("res_hit", 64'(res_hit), 64'(hit));
    check("res_idx", 64'(res_idx), 64'(idx));
    check("res_t", 64'(res_t), 64'(t));
    check("res_oa", 64'(res_oa), 64'(oa));
  endtask

  task automatic handshake();
    res_ready = 1'b1;
    tick();
    res_ready = 1'b0;
    check("ray_ready_after_hs", 64'(ray_ready), 64'd1);
    check("res_valid_after_hs", 64'(res_valid), 64'd0);
  endtask

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_ray_ready", 64'(ray_ready), 64'd1);
    check("rst_res_valid", 64'(res_valid), 64'd0);
    check("rst_tri_issue", 64'(tri_issue), 64'd0);
    check("rst_res_idx", 64'(res_idx), 64'd0);
    check("rst_dir_out", 64'(dir_out[0]), 64'd0);
    rst = 1'b0;
    tick();

    // Nearest hit: idx1 distance 2.0, idx3 distance 1.5
    clear_tab();
    tab_hit[1] = 1'b1; tab_t[1] = TWO;   tab_oa[1] = ONE;
    tab_hit[3] = 1'b1; tab_t[3] = THREE; tab_oa[3] = TWO;
    $display("vector nearest: hits idx1 (2.0/1.0) idx3 (3.0/2.0)");
    start_ray(ONE);
    run_sweep();
    check_result(1'b1, 3, 27'sd12582912, 27'sd8388608);

    // Backpressure: result held, no second accept
    $display("vector backpressure: res_ready low 5 cycles with ray_valid high");
    ray_dir[0] = TWO;
    ray_valid  = 1'b1;
    for (int n = 0; n < 5; n++) begin
      tick();
      check("bp_ray_ready", 64'(ray_ready), 64'd0);
      check("bp_res_valid", 64'(res_valid), 64'd1);
      check("bp_res_idx", 64'(res_idx), 64'd3);
      check("bp_res_t", 64'(res_t), 64'(THREE));
    end
    check("bp_dir_held", 64'(dir_out[0]), 64'(ONE));
    ray_valid = 1'b0;
    handshake();

    // No qualifying hit: zero and negative determinants
    clear_tab();
    tab_hit[2] = 1'b1; tab_t[2] = ONE; tab_oa[2] = '0;
    tab_hit[1] = 1'b1; tab_t[1] = ONE; tab_oa[1] = -ONE;
    $display("vector nohit: idx2 oa=0, idx1 oa=-1.0");
    start_ray(THREE);
    run_sweep();
    check_result(1'b0, 0, '0, '0);
    handshake();

    // Tie: equal distances keep the earlier index
    clear_tab();
    tab_hit[0] = 1'b1; tab_t[0] = ONE; tab_oa[0] = ONE;
    tab_hit[2] = 1'b1; tab_t[2] = TWO; tab_oa[2] = TWO;
    $display("vector tie: idx0 (1.0/1.0) idx2 (2.0/2.0)");
    start_ray(ONE);
    run_sweep();
    check_result(1'b1, 0, ONE, ONE);
    handshake();

    // Reset during ISSUE at idx2, then a fresh ray with one hit at idx1
    clear_tab();
    tab_hit[0] = 1'b1; tab_t[0] = EIGHTH; tab_oa[0] = ONE;
    $display("vector abort: reset while issuing idx2");
    start_ray(TWO);
    drive_isect(1);
    tick();
    drive_isect(2);
    tick();
    check("abort_idx2", 64'(tri_idx), 64'd2);
    rst = 1'b1;
    #1;
    check("abort_tri_issue", 64'(tri_issue), 64'd0);
    check("abort_ray_ready", 64'(ray_ready), 64'd1);
    repeat (3) tick();
    check("abort_res_valid", 64'(res_valid), 64'd0);
    check("abort_res_idx", 64'(res_idx), 64'd0);
    rst = 1'b0;
    tick();
    clear_tab();
    tab_hit[1] = 1'b1; tab_t[1] = ONE; tab_oa[1] = ONE;
    $display("vector after_abort: single hit idx1 (1.0/1.0)");
    start_ray(ONE);
    run_sweep();
    check_result(1'b1, 1, ONE, ONE);
    handshake();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
